// File: rtl/mux_arbiter.sv
// Two-requester arbiter driving a shared data mux. Ownership is granted
// in round-robin order on contention. A contended owner is preempted after
// MAX_HOLD accepted transfers. Handover between requesters happens with no
// idle cycle in between.
module mux_arbiter #(
   parameter int WIDTH    = 8,
   parameter int MAX_HOLD = 4
) (
   input  logic             CLK,
   input  logic             RSTN,
   input  logic             REQ0,
   input  logic             REQ1,
   input  logic [WIDTH-1:0] I0,
   input  logic [WIDTH-1:0] I1,
   input  logic             O_READY,
   output logic             GNT0,
   output logic             GNT1,
   output logic             S,
   output logic [WIDTH-1:0] O,
   output logic             O_VALID
);

   localparam int CW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
   // The transfer that brings the count to MAX_HOLD is the last one of a turn.
   localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

   typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

   state_t        state, state_nxt;
   logic          last, last_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          xfer;
   logic          hold_done;

   assign xfer      = O_VALID & O_READY;
   assign hold_done = xfer && (cnt == HOLD_LAST);

   // State, last-granted and beat counter registers; reset favours requester 0
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state <= IDLE;
         last  <= 1'b1;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         last  <= last_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next-state arbitration, hold-limit preemption and counter update
   always_comb begin
      state_nxt = state;
      last_nxt  = last;
      cnt_nxt   = xfer ? cnt + CW'(1) : cnt;
      case (state)
         IDLE: begin
            if (REQ0 && (!REQ1 || last)) state_nxt = OWN0;
            else if (REQ1)               state_nxt = OWN1;
         end
         OWN0: begin
            if (!REQ0) begin
               state_nxt = REQ1 ? OWN1 : IDLE;
            end else if (hold_done) begin
               // Uncontended owner keeps the path but starts a fresh turn
               if (REQ1) state_nxt = OWN1;
               else      cnt_nxt   = '0;
            end
         end
         OWN1: begin
            if (!REQ1) begin
               state_nxt = REQ0 ? OWN0 : IDLE;
            end else if (hold_done) begin
               if (REQ0) state_nxt = OWN0;
               else      cnt_nxt   = '0;
            end
         end
         default: state_nxt = IDLE;
      endcase
      // Every state entry restarts the turn and records the new owner
      if (state_nxt != state) begin
         cnt_nxt = '0;
         if (state_nxt == OWN0)      last_nxt = 1'b0;
         else if (state_nxt == OWN1) last_nxt = 1'b1;
      end
   end

   // Moore grants and select; valid also needs the owner still requesting
   always_comb begin
      GNT0    = (state == OWN0);
      GNT1    = (state == OWN1);
      S       = (state == OWN1);
      O_VALID = ((state == OWN0) & REQ0) | ((state == OWN1) & REQ1);
      O       = S ? I1 : I0;
   end

endmodule

// File: doc/mux_arbiter.md
MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, data width of each requester and of the shared output.
REQ-002 Parameter MAX_HOLD, default 4, number of accepted transfers after which a contended owner is preempted.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset; all state SHALL clear immediately on RSTN low, independent of CLK.
REQ-004 CLK  input  1  sole clock; all state updates on rising edge.
REQ-005 RSTN  input  1  asynchronous active-low reset.
REQ-006 REQ0  input  1  requester 0 wants the shared path; held high while it has data.
REQ-007 REQ1  input  1  requester 1 wants the shared path.
REQ-008 I0  input  WIDTH  requester 0 data.
REQ-009 I1  input  WIDTH  requester 1 data.
REQ-010 O_READY  input  1  downstream accepts O this cycle.
REQ-011 GNT0  output  1  requester 0 owns the path.
REQ-012 GNT1  output  1  requester 1 owns the path.
REQ-013 S  output  1  mux select: 0 selects I0, 1 selects I1.
REQ-014 O  output  WIDTH  shared data, S ? I1 : I0.
REQ-015 O_VALID  output  1  O carries valid data this cycle.

Function
REQ-016 FSM SHALL have exactly three registered states: IDLE, OWN0, OWN1; GNT0=1 only in OWN0, GNT1=1 only in OWN1 (Moore, never both high).
REQ-017 S SHALL be 1 in OWN1 and 0 in IDLE and OWN0; O SHALL be combinational from S, I0, I1.
REQ-018 O_VALID SHALL equal (OWN0 & REQ0) | (OWN1 & REQ1); transfer = O_VALID & O_READY.
REQ-019 Register LAST (1 bit) SHALL record the most recently granted requester; set to x on entry to OWNx.
REQ-020 IDLE: REQ0 only -> OWN0; REQ1 only -> OWN1; both -> requester != LAST; neither -> stay IDLE.
REQ-021 Grant latency SHALL be one cycle: REQ high at edge n in IDLE -> GNTx high after edge n.
REQ-022 Beat counter (ceil(log2(MAX_HOLD+1)) bits) SHALL clear on every state entry and increment on each transfer.
REQ-023 OWNx with REQx low SHALL leave: to OWNother if REQother high, else IDLE; no idle bubble on handover.
REQ-024 OWNx with REQx high, transfer occurring and counter reaching MAX_HOLD: if REQother high -> OWNother; else stay OWNx with counter cleared.
REQ-025 Counter SHALL NOT advance while O_READY low; the owner keeps the grant indefinitely under backpressure.
REQ-026 Requester dropping REQ and other raising REQ in the same cycle SHALL hand over directly per REQ-023.
REQ-027 Both requests low in the same cycle the owner drops SHALL return to IDLE.

Reset
REQ-028 On RSTN low: state=IDLE, LAST=1, counter=0, GNT0=0, GNT1=0, S=0, O_VALID=0; O=I0.
REQ-029 Reset asserted mid-grant SHALL abort the grant at once; first arbitration after release favours requester 0 on contention.

Verification
REQ-030 Reset, then REQ0=REQ1=1 same cycle -> GNT0=1 after first edge, S=0, O=I0.
REQ-031 REQ0 only, I0=8'hA5, O_READY=1 -> GNT0 next edge, O_VALID=1, O=8'hA5; drop REQ0 -> IDLE next edge, O_VALID=0.
REQ-032 Both requesting, O_READY=1, MAX_HOLD=4 -> exactly 4 transfers from I0, then GNT1=1, S=1, 4 transfers from I1, then back to GNT0.
REQ-033 OWN1 with O_READY=0 for 10 cycles, REQ0 high -> GNT1 held all 10 cycles, counter stays 0.
REQ-034 OWN0, REQ0 falls while REQ1 rises -> GNT1=1 after next edge, no IDLE cycle, O switches to I1.
REQ-035 RSTN pulsed low mid-OWN1 between edges -> GNT1, S, O_VALID drop to 0 without a clock edge.
